// File: rtl/pipo_pipe_reg.sv
// Elastic PIPO pipeline: DEPTH register stages of WIDTH-bit words with valid/ready
// handshake on both sides, bubble collapse, synchronous flush and occupancy count.
module pipo_pipe_reg #(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_src_valid;
  logic [WIDTH-1:0] w_src_data [DEPTH];
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [CW-1:0]    w_count_nxt;

  always_comb begin
    w_src_valid    = '0;
    w_src_valid[0] = in_valid;
    w_src_data[0]  = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      w_src_valid[i] = r_valid[i-1];
      w_src_data[i]  = r_data[i-1];
    end
  end

  // Ready chain walks from the output stage back to stage 0; a running scalar
  // keeps w_ready write-only inside this block.
  always_comb begin : ready_chain
    logic v_run;
    w_ready = '0;
    v_run   = out_ready;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      v_run                = !r_valid[DEPTH-1-k] | v_run;
      w_ready[DEPTH-1-k]   = v_run;
    end
  end

  assign in_ready   = w_ready[0];
  assign w_in_xfer  = in_valid & w_ready[0];
  assign w_out_xfer = r_valid[DEPTH-1] & out_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_in_xfer, w_out_xfer})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else if (flush) begin
      // Words are dropped but data registers keep their contents.
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (w_ready[i]) r_valid[i] <= w_src_valid[i];
        if (w_ready[i] && w_src_valid[i]) r_data[i] <= w_src_data[i];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign out_data  = r_data[DEPTH-1];
  assign count     = r_count;

endmodule
